shift_stage_16bit: RTL
======================

# shift_stage_16bit

Registered, handshaked shift/rotate stage for the Level 2 ALU datapath. It sits directly downstream of the ALU operand selection and drives the ALU result bus. Each accepted request carries a 16-bit operand, a 4-bit shift amount and an opcode. The block computes the shifted or rotated value plus carry, zero and negative flags, and holds results in a 2-entry output buffer with valid/ready flow control on both sides.

## Interface
Parameters:
- none (width fixed at 16, shift amount fixed at 4 bits)

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  stage can accept a request this cycle.
- in_data  in  16  operand.
- in_shift  in  4  shift/rotate amount, 0..15.
- in_op  in  3  000 ROR, 001 ROL, 010 SRL, 011 SRA, 100 SLL, 101–111 PASS.
- out_valid  out  1  result at buffer head.
- out_ready  in  1  consumer takes the head result this cycle.
- out_data  out  16  result value.
- out_carry  out  1  last bit shifted or rotated out.
- out_zero  out  1  out_data == 0.
- out_neg  out  1  out_data[15].

## Operation
- **Handshake**
  - Accept on an edge with in_valid && in_ready.
  - Pop on an edge with out_valid && out_ready.
- **Buffer**
  - 2-entry FIFO of {data, carry, zero, neg}, with count 0..2.
  - in_ready = (count != 2). It does not depend on out_ready, so there is no combinational ready path.
  - out_valid = (count != 0). out_* always show the head entry.
- **Result function**, with n = in_shift:
  - ROR: {in[n-1:0], in[15:n]}; carry = in[n-1].
  - ROL: {in[15-n:0], in[15:16-n]}; carry = in[16-n].
  - SRL: in >> n, zero-filled; carry = in[n-1].
  - SRA: in >>> n, sign-filled; carry = in[n-1].
  - SLL: in << n, zero-filled; carry = in[16-n].
  - PASS: out = in; carry = 0.
  - n = 0, any op: out = in, carry = 0.
  - zero and neg are computed from the result value. All flags are stored with the entry.
- **Simultaneous events**
  - count 0, push only: count becomes 1.
  - count 1, push and pop: count stays 1; the new result becomes head.
  - count 2: push is blocked (in_ready = 0); a pop gives count 1.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- Unused opcodes are not errors; they behave as PASS.

## Timing
- **Latency**: a request accepted at edge k is visible at out_* after edge k when the buffer was empty, or behind older entries otherwise.
- **Throughput**: 1 result per cycle while out_ready is held high.
- **Reset** (asserted asynchronously, released synchronously with clk):
  - count = 0, in_ready = 1, out_valid = 0.
  - out_data = 0x0000, out_carry = 0, out_zero = 0, out_neg = 0.
  - Buffer storage is cleared to zero.
- **Reset mid-operation**: all buffered results are discarded immediately. No out_valid is produced for requests accepted before reset.
- **out_data/flags while out_valid = 0**: hold the last head contents, or zero after reset. Consumers must ignore them.
- **Stable-under-stall**: while out_valid && !out_ready, out_* do not change, even if a push occurs behind the head.

## Test plan
- **Reset**: assert rst_n = 0 mid-cycle with 2 entries buffered → all outputs zero and in_ready = 1 immediately; out_valid = 0 after release.
- **Rotates**:
  - ROR 0x8001 by 1 → 0xC000, carry 1, neg 1, zero 0.
  - ROR 0x1234 by 4 → 0x4123, carry 0.
  - ROL 0x1234 by 4 → 0x2341, carry 1.
- **Shifts**:
  - SRA 0x8000 by 15 → 0xFFFF, carry 0, neg 1.
  - SRL 0x8000 by 15 → 0x0001.
  - SLL 0x0001 by 15 → 0x8000, carry 0.
  - SRL 0x0001 by 1 → 0x0000, carry 1, zero 1.
- **Boundaries**:
  - Every op with shift 0 on 0xA5A5 → 0xA5A5, carry 0.
  - op 110 on 0x00FF by 3 → 0x00FF, carry 0.
- **Backpressure**: out_ready = 0; present ROR 0x0001 by 1, then ROR 0x0002 by 1, then ROR 0x0004 by 1, back-to-back.
  - First two are accepted; in_ready = 0 with the third held.
  - Raise out_ready → 0x8000, 0x0001, 0x0002 in order. Head is stable during the stall.
- **Streaming**: out_ready = 1; 32 random back-to-back requests → 32 results in 32 consecutive cycles, matching a reference model bit-exact, including flags.

Source files
------------

// File: rtl/shift_stage_16bit.sv
// -----------------------------------------------------------------------------
// shift_stage_16bit
//
// Registered shift/rotate stage for the ALU datapath. Each accepted request
// carries a 16-bit operand, a 4-bit amount and a 3-bit opcode. The shifted or
// rotated result is computed combinationally from the request and written,
// together with carry/zero/negative flags, into a 2-entry output FIFO. The
// FIFO head drives the result bus.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   request present
//   in_ready   out  1   stage can accept a request this cycle
//   in_data    in  16   operand
//   in_shift   in   4   shift/rotate amount 0..15
//   in_op      in   3   000 ROR, 001 ROL, 010 SRL, 011 SRA, 100 SLL, else PASS
//   out_valid  out  1   result present at buffer head
//   out_ready  in   1   consumer takes the head this cycle
//   out_data   out 16   head result value
//   out_carry  out  1   last bit shifted/rotated out
//   out_zero   out  1   head result == 0
//   out_neg    out  1   head result bit 15
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on the buffer fill level (never on out_ready),
// and out_valid only on the fill level, so there is no combinational path
// between the two sides. A producer may not withdraw or change a request while
// valid is high and ready is low.
// -----------------------------------------------------------------------------
module shift_stage_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_shift,
  input  logic [2:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_carry,
  output logic        out_zero,
  output logic        out_neg
);

  // ---------------------------------------------------------------------------
  // Opcodes
  // ---------------------------------------------------------------------------
  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;

  // Buffer fill levels
  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  // One buffered result: value plus the flags captured with it.
  typedef struct packed {
    logic [15:0] data;
    logic        carry;
    logic        zero;
    logic        neg;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Result function
  // ---------------------------------------------------------------------------
  logic [31:0] w_dbl;        // operand concatenated with itself for rotates
  logic [31:0] w_ror_full;
  logic [31:0] w_rol_full;
  logic [15:0] w_ror;
  logic [15:0] w_rol;
  logic [15:0] w_srl;
  logic [15:0] w_sra;
  logic [15:0] w_sll;
  logic [3:0]  w_idx_right;  // n-1: last bit leaving through the LSB end
  logic [3:0]  w_idx_left;   // 16-n: last bit leaving through the MSB end
  logic        w_carry_right;
  logic        w_carry_left;
  logic        w_shift_nz;
  logic [15:0] w_res_data;
  logic        w_res_carry;
  entry_t      w_new;

  assign w_dbl      = {in_data, in_data};
  assign w_ror_full = w_dbl >> in_shift;
  assign w_rol_full = w_dbl << in_shift;
  assign w_ror      = w_ror_full[15:0];
  assign w_rol      = w_rol_full[31:16];
  assign w_srl      = in_data >> in_shift;
  assign w_sra      = $signed(in_data) >>> in_shift;
  assign w_sll      = in_data << in_shift;

  // For n = 0 these indices wrap to 15 and 0; the carry is forced to zero in
  // that case below, so the wrapped value is never used.
  assign w_idx_right   = in_shift - 4'd1;
  assign w_idx_left    = 4'd0 - in_shift;
  assign w_carry_right = in_data[w_idx_right];
  assign w_carry_left  = in_data[w_idx_left];
  assign w_shift_nz    = (in_shift != 4'd0);

  always_comb begin
    w_res_data  = in_data;
    w_res_carry = 1'b0;
    case (in_op)
      OP_ROR: begin
        w_res_data  = w_ror;
        w_res_carry = w_carry_right;
      end
      OP_ROL: begin
        w_res_data  = w_rol;
        w_res_carry = w_carry_left;
      end
      OP_SRL: begin
        w_res_data  = w_srl;
        w_res_carry = w_carry_right;
      end
      OP_SRA: begin
        w_res_data  = w_sra;
        w_res_carry = w_carry_right;
      end
      OP_SLL: begin
        w_res_data  = w_sll;
        w_res_carry = w_carry_left;
      end
      default: begin
        // Unused opcodes pass the operand through with no carry.
        w_res_data  = in_data;
        w_res_carry = 1'b0;
      end
    endcase
    // A zero amount shifts nothing out: value is the operand, carry clear.
    if (!w_shift_nz) begin
      w_res_data  = in_data;
      w_res_carry = 1'b0;
    end
  end

  always_comb begin
    w_new.data  = w_res_data;
    w_new.carry = w_res_carry;
    w_new.zero  = (w_res_data == 16'h0000);
    w_new.neg   = w_res_data[15];
  end

  // ---------------------------------------------------------------------------
  // 2-entry output buffer
  //
  // Organised as a head register (drives out_*) and a tail register behind
  // it rather than a pointer-based RAM. This keeps out_* a direct register
  // output, which makes "head stable while stalled" automatic: the head
  // register only changes on a pop, or on a push into an empty buffer.
  // ---------------------------------------------------------------------------
  logic [1:0] r_count;
  entry_t     r_head;
  entry_t     r_tail;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_nxt;
  entry_t     w_head_nxt;
  entry_t     w_tail_nxt;

  assign in_ready  = (r_count != CNT_FULL);
  assign out_valid = (r_count != CNT_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    w_count_nxt = r_count;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case ({w_push, w_pop})
      2'b10: begin
        // Push only: fills the head if empty, otherwise queues behind it.
        if (r_count == CNT_EMPTY) begin
          w_head_nxt = w_new;
        end else begin
          w_tail_nxt = w_new;
        end
        w_count_nxt = r_count + 2'd1;
      end
      2'b01: begin
        // Pop only: the tail advances when there is one. With a single entry
        // the head keeps its old contents (shown while out_valid is low).
        if (r_count == CNT_FULL) begin
          w_head_nxt = r_tail;
        end
        w_count_nxt = r_count - 2'd1;
      end
      2'b11: begin
        // Push and pop together can only happen with exactly one entry
        // (push needs count != 2, pop needs count != 0): the new result
        // replaces the departing head and the fill level is unchanged.
        w_head_nxt = w_new;
      end
      default: begin
        w_count_nxt = r_count;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= CNT_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

  assign out_data  = r_head.data;
  assign out_carry = r_head.carry;
  assign out_zero  = r_head.zero;
  assign out_neg   = r_head.neg;

  // CNT_ONE is named for readability of the fill-level encoding; reference it
  // so the encoding stays documented in one place.
  logic w_unused_one;
  assign w_unused_one = (r_count == CNT_ONE);

endmodule
